avalon_switch_pio: RTL
======================

AVALON_SWITCH_PIO -- requirements
Module: avalon_switch_pio

Interface
REQ-001 Parameter WIDTH, default 2, is the number of switch inputs and the number of LED outputs (1..32).
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000, is the number of cycles an input must be stable before it is accepted (1 ms at 50 MHz; minimum 1).
REQ-003 Port clk  in  1  is the single system clock; all state SHALL be on its rising edge.
REQ-004 Port reset  in  1  is the reset: asynchronous, active-high.
REQ-005 Port avs_address  in  2  is the Avalon-MM slave word address.
REQ-006 Port avs_read  in  1  is the read strobe.
REQ-007 Port avs_write  in  1  is the write strobe.
REQ-008 Port avs_writedata  in  32  is the write data.
REQ-009 Port avs_readdata  out  32  is the read data; it SHALL be valid exactly one cycle after avs_read (fixed read latency 1, no waitrequest).
REQ-010 Port sw_in  in  WIDTH  is the raw asynchronous switch inputs.
REQ-011 Port led_out  out  WIDTH  is the registered LED drive.
REQ-012 Port irq  out  1  is a registered level interrupt to the processor.

Function
REQ-013 The register map SHALL be:
- 0 DATA (RO): debounced switch state.
- 1 LED (RW): drives led_out.
- 2 IRQ_MASK (RW).
- 3 EDGE (read; write-1-to-clear).
REQ-014 Bits above WIDTH SHALL read 0 and SHALL ignore writes; a write to DATA SHALL have no effect.
REQ-015 sw_in SHALL pass through a 2-flop synchronizer per bit before any other use.
REQ-016 Each bit SHALL have a counter that increments while the synchronized value differs from the debounced value, and clears when they are equal.
REQ-017 When a bit's counter reaches DEBOUNCE_CYCLES-1 and the values still differ, the debounced bit SHALL take the synchronized value and the counter SHALL clear. A change held stable is therefore visible in DATA 2+DEBOUNCE_CYCLES cycles after the pin edge.
REQ-018 A glitch shorter than DEBOUNCE_CYCLES cycles (after synchronization) SHALL NOT change DATA.
REQ-019 Any change of a debounced bit, rising or falling, SHALL set the matching EDGE bit on the same clock edge as the DATA update.
REQ-020 Writing 1 to an EDGE bit SHALL clear it. If a new edge on that bit occurs in the same cycle, the set SHALL win and the bit SHALL stay 1.
REQ-021 irq SHALL be the registered OR of (EDGE & IRQ_MASK): it asserts one cycle after the causing edge/mask change and deasserts one cycle after clear/unmask.
REQ-022 LED writes SHALL update led_out on the clock edge that samples avs_write.
REQ-023 For a read and a write to the same address in the same cycle, the write SHALL take effect and avs_readdata SHALL return the pre-write value.
REQ-024 avs_readdata SHALL hold its last value when avs_read is low.

Reset
REQ-025 When reset asserts, all of the following SHALL clear to 0 immediately, independent of clk: led_out, irq, avs_readdata, IRQ_MASK, EDGE, the debounced state, counters and synchronizers.
REQ-026 Reset asserted mid-debounce SHALL discard the partial count. After release, a switch already high SHALL produce one rising EDGE event once it is debounced.

Configuration
REQ-027 With macro SWITCH_PIO_DEBOUNCE_EN defined, the debounce counters of REQ-016..018 SHALL be built.
REQ-028 With SWITCH_PIO_DEBOUNCE_EN undefined, no counters SHALL exist and the debounced value SHALL equal the synchronizer output (DATA latency 2 cycles). DEBOUNCE_CYCLES is then ignored; all other behaviour is unchanged.

Verification (bench uses WIDTH=2, DEBOUNCE_CYCLES=4, macro defined unless stated)
REQ-029 Release reset with sw_in=2'b00, drive sw_in[0]=1 and hold -> DATA reads 0x1 from cycle 6 after the edge, EDGE reads 0x1, irq stays 0 (mask 0).
REQ-030 Pulse sw_in[1] high for 3 cycles -> DATA and EDGE remain 0x0.
REQ-031 Write IRQ_MASK=0x2, hold sw_in[1] high -> irq asserts one cycle after EDGE[1] sets; write EDGE=0x2 -> irq deasserts one cycle later.
REQ-032 Write LED=0xFFFFFFFF, then read LED -> led_out=2'b11, readdata=0x00000003 one cycle after avs_read.
REQ-033 Write EDGE=0x1 in the same cycle as a new debounced edge on bit 0 -> EDGE[0] remains 1.
REQ-034 With the macro undefined, toggle sw_in[0] -> DATA follows after 2 cycles, including 1-cycle pulses that last long enough to be sampled.

Source files
------------

// File: rtl/avalon_switch_pio.sv
// Avalon-MM switch/LED PIO: synchronized, optionally debounced switch inputs with
// change-capture EDGE register and masked level interrupt. Debounce built with SWITCH_PIO_DEBOUNCE_EN.
module avalon_switch_pio #(
  parameter int unsigned WIDTH           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] led_out,
  output logic             irq
);

  localparam int unsigned DW = 32;

  if (WIDTH < 1 || WIDTH > 32 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("avalon_switch_pio: WIDTH must be 1..32 and DEBOUNCE_CYCLES at least 1");
  end

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [WIDTH-1:0] chg_c;
  logic [WIDTH-1:0] mask_q, edge_q;
  logic [WIDTH-1:0] wdata_c, edge_clr_c;
  logic             wr_led_c, wr_mask_c, wr_edge_c;
  logic [DW-1:0]    rdata_c;

  // Two-flop synchronizer on the raw switch pins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef SWITCH_PIO_DEBOUNCE_EN
  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q [WIDTH];

  // Per-bit run counter: counts consecutive cycles the synchronized value disagrees
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2_q[i] == deb_q[i] || cnt_q[i] == CNT_MAX) cnt_q[i] <= '0;
        else                                                cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] != deb_q[i] && cnt_q[i] == CNT_MAX) deb_d[i] = sync2_q[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) deb_q <= '0;
    else       deb_q <= deb_d;
  end
`else
  // Without debounce the synchronizer output is the accepted state; its next value is sync1
  always_comb begin
    deb_q = sync2_q;
    deb_d = sync1_q;
  end
`endif

  always_comb begin
    chg_c      = deb_d ^ deb_q;
    wdata_c    = avs_writedata[WIDTH-1:0];
    wr_led_c   = avs_write && (avs_address == 2'd1);
    wr_mask_c  = avs_write && (avs_address == 2'd2);
    wr_edge_c  = avs_write && (avs_address == 2'd3);
    edge_clr_c = wr_edge_c ? wdata_c : '0;
  end

  // Read mux sees pre-write register values
  always_comb begin
    rdata_c = '0;
    case (avs_address)
      2'd0:    rdata_c = DW'(deb_q);
      2'd1:    rdata_c = DW'(led_out);
      2'd2:    rdata_c = DW'(mask_q);
      default: rdata_c = DW'(edge_q);
    endcase
  end

  // Register file, interrupt and read data; a new edge beats a same-cycle clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_out      <= '0;
      mask_q       <= '0;
      edge_q       <= '0;
      irq          <= 1'b0;
      avs_readdata <= '0;
    end else begin
      if (wr_led_c)  led_out <= wdata_c;
      if (wr_mask_c) mask_q  <= wdata_c;
      edge_q <= (edge_q & ~edge_clr_c) | chg_c;
      irq    <= |(edge_q & mask_q);
      if (avs_read) avs_readdata <= rdata_c;
    end
  end

endmodule
